// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: fetch enable, instruction-memory request/response,
// execute redirect and the decode valid/ready handshake.
interface inst_fetch_if;
  logic        fetch_en;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  modport master (
    input  fetch_en,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  redirect_valid, redirect_pc,
    output inst_valid, instruction, inst_pc,
    input  inst_ready
  );

  modport slave (
    output fetch_en,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output redirect_valid, redirect_pc,
    input  inst_valid, instruction, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC, credit-limited imem requests, in-order fetch FIFO,
// redirect flush/drain. Define FETCH_STALL_CNT_EN to add the stall_count output.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 3
) (
  input logic          clk,
  input logic          rst_n,
  inst_fetch_if.master bus
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]  stall_count
`endif
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [1:0]  IDLE  = 2'd0;
  localparam logic [1:0]  FETCH = 2'd1;
  localparam logic [1:0]  DRAIN = 2'd2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] out_q, out_d, drop_q, drop_d, count_q, count_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d, pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;
  logic [31:0]      data_q [FIFO_DEPTH];
  logic [31:0]      data_d [FIFO_DEPTH];
  logic [31:0]      pcs_q  [FIFO_DEPTH];
  logic [31:0]      pcs_d  [FIFO_DEPTH];
  logic [31:0]      pq_q   [FIFO_DEPTH];
  logic [31:0]      pq_d   [FIFO_DEPTH];

  logic [CNT_W:0] credit_used;
  logic req_valid, acc, rsp, rsp_keep, rsp_drop, pop, push;

  always_comb begin
    credit_used = (CNT_W+1)'(count_q) + (CNT_W+1)'(out_q);
    req_valid   = (state_q == FETCH) && bus.fetch_en && (credit_used < (CNT_W+1)'(FIFO_DEPTH));
    acc         = req_valid && bus.imem_req_ready;
    rsp         = bus.imem_rsp_valid;
    rsp_drop    = rsp && (drop_q != '0);
    rsp_keep    = rsp && (drop_q == '0);
    pop         = (count_q != '0) && bus.inst_ready;
    push        = rsp_keep && !bus.redirect_valid;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    out_d   = out_q;
    drop_d  = drop_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    pq_wr_d = pq_wr_q;
    pq_rd_d = pq_rd_q;
    data_d  = data_q;
    pcs_d   = pcs_q;
    pq_d    = pq_q;
    if (bus.redirect_valid) begin
      // Everything still in flight (incl. a request accepted now) becomes drop
      // credit; a response arriving now retires one of those either way.
      pc_d    = {bus.redirect_pc[31:2], 2'b00};
      drop_d  = drop_q + out_q + CNT_W'(acc) - CNT_W'(rsp);
      out_d   = '0;
      count_d = '0;
      wr_d    = '0;
      rd_d    = '0;
      pq_wr_d = '0;
      pq_rd_d = '0;
      state_d = (drop_d != '0) ? DRAIN : FETCH;
    end else begin
      if (acc) begin
        pc_d           = pc_q + 32'd4;
        pq_d[pq_wr_q]  = pc_q;
        pq_wr_d        = pq_wr_q + PTR_W'(1);
      end
      if (push) begin
        data_d[wr_q] = bus.imem_rsp_data;
        pcs_d[wr_q]  = pq_q[pq_rd_q];
        wr_d         = wr_q + PTR_W'(1);
        pq_rd_d      = pq_rd_q + PTR_W'(1);
      end
      if (pop) rd_d = rd_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      out_d   = out_q + CNT_W'(acc) - CNT_W'(rsp_keep);
      drop_d  = drop_q - CNT_W'(rsp_drop);
      case (state_q)
        IDLE:    if (bus.fetch_en) state_d = FETCH;
        FETCH:   if (!bus.fetch_en && out_d == '0) state_d = IDLE;
        DRAIN:   if (drop_d == '0) state_d = bus.fetch_en ? FETCH : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      out_q   <= '0;
      drop_q  <= '0;
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      pq_wr_q <= '0;
      pq_rd_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        data_q[i] <= NOP;
        pcs_q[i]  <= '0;
        pq_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      out_q   <= out_d;
      drop_q  <= drop_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pq_wr_q <= pq_wr_d;
      pq_rd_q <= pq_rd_d;
      data_q  <= data_d;
      pcs_q   <= pcs_d;
      pq_q    <= pq_d;
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = (count_q != '0);
  assign bus.instruction    = data_q[rd_q];
  assign bus.inst_pc        = pcs_q[rd_q];

  // The request credit limit makes this unreachable.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == CNT_W'(FIFO_DEPTH)));

`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.inst_ready && count_q == '0 && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`endif
endmodule
